// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a 1-write/2-read data memory.
// Clears every location after reset, then grants one requester per cycle.
module mem_port_arbiter #(
  parameter int DW         = 12,
  parameter int AW         = 3,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_waddr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [AW-1:0] r0_raddr_a,
  input  logic [AW-1:0] r0_raddr_b,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_waddr,
  input  logic [DW-1:0] r1_wdata,
  input  logic [AW-1:0] r1_raddr_a,
  input  logic [AW-1:0] r1_raddr_b,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          busy,
  output logic          mem_write,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic [AW-1:0] mem_rd_addr_a,
  output logic [AW-1:0] mem_rd_addr_b,
  input  logic [DW-1:0] mem_rd_data_a,
  input  logic [DW-1:0] mem_rd_data_b
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_addr, clr_addr_next;
  logic          rr_ptr, rr_ptr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_CLEAR ? CLEAR : RUN;
      clr_addr  <= '0;
      rr_ptr    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      state     <= state_next;
      clr_addr  <= clr_addr_next;
      rr_ptr    <= rr_ptr_next;
      r0_rvalid <= r0_gnt;
      r1_rvalid <= r1_gnt;
    end
  end

  // rr_ptr==1 means port 1 wins the next contention
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    rr_ptr_next   = rr_ptr;
    r0_gnt        = 1'b0;
    r1_gnt        = 1'b0;
    mem_write     = 1'b0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;
    mem_rd_addr_a = '0;
    mem_rd_addr_b = '0;
    if (!rst) begin
      case (state)
        CLEAR: begin
          mem_write     = 1'b1;
          mem_wr_addr   = clr_addr;
          clr_addr_next = clr_addr + AW'(1);
          if (clr_addr == {AW{1'b1}})
            state_next = RUN;
        end
        RUN: begin
          if (r0_req && (!r1_req || !rr_ptr)) begin
            r0_gnt        = 1'b1;
            rr_ptr_next   = 1'b1;
            mem_write     = r0_we;
            mem_wr_addr   = r0_waddr;
            mem_wr_data   = r0_wdata;
            mem_rd_addr_a = r0_raddr_a;
            mem_rd_addr_b = r0_raddr_b;
          end else if (r1_req) begin
            r1_gnt        = 1'b1;
            rr_ptr_next   = 1'b0;
            mem_write     = r1_we;
            mem_wr_addr   = r1_waddr;
            mem_wr_data   = r1_wdata;
            mem_rd_addr_a = r1_raddr_a;
            mem_rd_addr_b = r1_raddr_b;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign busy    = (state == CLEAR);
  assign rdata_a = mem_rd_data_a;
  assign rdata_b = mem_rd_data_b;

endmodule
